clut_lookup: RTL and testbench

Colour-lookup stage directly downstream of the run-length/mosaic decoder in each video plane path. It takes the 8-bit pixel index stream, applies the plane-dependent index mapping and reads a 256 × 24-bit palette RAM written by the CPU-side register block. It emits a 24-bit RGB stream towards the plane mixer at one pixel per clock, and provides full backpressure through a small output buffer.

---
 rtl/clut_lookup_pkg.sv | 46 ++++
 rtl/pixelstream.sv | 18 +
 rtl/rgbstream.sv | 18 +
 rtl/clut_ram.sv | 37 +++
 rtl/clut_lookup.sv | 100 ++++++++++
 tb/tb_clut_lookup.sv | 269 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/clut_lookup_pkg.sv
// ----------------------------------------------------------------------------
// clut_lookup_pkg
//   Shared types for the colour-lookup stage: coding-method enum, RGB888
//   pixel struct, palette geometry and the plane-dependent index mapping.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package clut_lookup_pkg;

  typedef enum logic [1:0] {
    kClut8 = 2'd0,
    kClut7 = 2'd1,
    kClut4 = 2'd2
  } clut_mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam int CLUT_AW    = 8;
  localparam int CLUT_DEPTH = 1 << CLUT_AW;
  localparam int CLUT_DW    = 24;

  // Map a raw pixel index to a palette address. The encoding 2'd3 is not a
  // legal coding method; it falls back to the full 8-bit mapping.
  function automatic logic [CLUT_AW-1:0] clut_index(
    input clut_mode_e  mode,
    input logic [7:0]  pixel,
    input logic        plane_b
  );
    logic [CLUT_AW-1:0] idx;
    idx = pixel;
    case (mode)
      kClut7:  idx = {plane_b, pixel[6:0]};
      kClut4:  idx = {4'b0000, pixel[3:0]};
      default: idx = pixel;
    endcase
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixelstream.sv
// ----------------------------------------------------------------------------
// pixelstream
//   8-bit pixel index stream with valid (write) / accept (strobe) handshake.
//   Ports: none (signal bundle); modports source / sink.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface pixelstream;
  logic [7:0] pixel;
  logic       write;
  logic       strobe;

  modport source (output pixel, output write, input  strobe);
  modport sink   (input  pixel, input  write, output strobe);
endinterface

`default_nettype wire

// File: rtl/rgbstream.sv
// ----------------------------------------------------------------------------
// rgbstream
//   24-bit RGB stream {R,G,B}, same handshake as pixelstream.
//   Ports: none (signal bundle); modports source / sink.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface rgbstream;
  logic [23:0] pixel;
  logic        write;
  logic        strobe;

  modport source (output pixel, output write, input  strobe);
  modport sink   (input  pixel, input  write, output strobe);
endinterface

`default_nettype wire

// File: rtl/clut_ram.sv
// ----------------------------------------------------------------------------
// clut_ram
//   256 x 24 simple dual-port palette RAM, synchronous 1-cycle read,
//   read-before-write on address collision. No reset on contents.
//   Ports: clk; we/waddr/wdata write port; re/raddr read port; rdata.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module clut_ram
  import clut_lookup_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [CLUT_AW-1:0] waddr,
  input  logic [CLUT_DW-1:0] wdata,
  input  logic               re,
  input  logic [CLUT_AW-1:0] raddr,
  output logic [CLUT_DW-1:0] rdata
);

  logic [CLUT_DW-1:0] mem [CLUT_DEPTH];

  // Both accesses in one process: the read samples mem before the
  // non-blocking write lands, which gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/clut_lookup.sv
// ----------------------------------------------------------------------------
// clut_lookup
//   Colour-lookup stage: maps pixel indices through a CPU-loaded palette and
//   emits RGB at one pixel per clock with full backpressure via a 2-entry
//   output FIFO and a credit check on the input.
//   Ports: clk, reset (sync, active-high); src pixel index sink; dst RGB
//   source; cm coding method; pal_we/pal_addr/pal_data palette write port.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module clut_lookup
  import clut_lookup_pkg::*;
#(
  parameter bit PLANE_B = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  pixelstream.sink           src,
  rgbstream.source           dst,
  input  clut_mode_e         cm,
  input  logic               pal_we,
  input  logic [CLUT_AW-1:0] pal_addr,
  input  logic [CLUT_DW-1:0] pal_data
);

  logic [CLUT_AW-1:0] idx;
  logic               accept;
  logic               pop;
  logic [2:0]         credit_sum;
  logic [CLUT_DW-1:0] rd_data;

  logic [1:0]         occ;
  logic               inflight;
  rgb888_t            head;
  rgb888_t            tail;

  assign idx = clut_index(cm, src.pixel, PLANE_B);

  assign pop = dst.write && dst.strobe;

  // Entries that will occupy the FIFO after this edge, before any new
  // accept. pop implies occ >= 1, so this never underflows.
  assign credit_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  assign src.strobe = src.write && !reset && (credit_sum < 3'd2);
  assign accept     = src.write && src.strobe;

  assign dst.write  = (occ != 2'd0);
  assign dst.pixel  = head;

  clut_ram u_ram (
    .clk   (clk),
    .we    (pal_we),
    .waddr (pal_addr),
    .wdata (pal_data),
    .re    (accept),
    .raddr (idx),
    .rdata (rd_data)
  );

  // Shift-style FIFO: head is always the oldest entry so dst.pixel needs no
  // read mux. A push arrives from the RAM one cycle after the accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= accept;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head <= rgb888_t'(rd_data);
          end else begin
            tail <= rgb888_t'(rd_data);
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= rgb888_t'(rd_data);
          end else begin
            head <= tail;
            tail <= rgb888_t'(rd_data);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clut_lookup.sv
// ----------------------------------------------------------------------------
// tb_clut_lookup
//   Self-checking bench for clut_lookup. Two instances (PLANE_B = 0 / 1)
//   share all stimulus; each has its own scoreboard queue.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_clut_lookup;
  import clut_lookup_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  src_pixel;
  logic        src_write;
  logic        dst_strobe;
  clut_mode_e  cm;
  logic        pal_we;
  logic [7:0]  pal_addr;
  logic [23:0] pal_data;

  logic        strobe_v [2];
  logic        dwrite_v [2];
  logic [23:0] dpix_v   [2];
  int          pend_v   [2];
  int          out_cnt  [2];
  int          first_out[2];
  int          last_out [2];

  logic [23:0] pal_model [256];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        toggle_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] tb_idx(input logic [7:0] p, input clut_mode_e m, input logic pb);
    case (m)
      kClut7:  return {pb, p[6:0]};
      kClut4:  return {4'h0, p[3:0]};
      default: return p;
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 256; k++) pal_model[k] = 24'h0;
  end

  // Reference palette: a write in cycle N is visible to reads sampled after it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pal_we) pal_model[pal_addr] <= pal_data;
  end

  always @(posedge clk) begin
    if (toggle_en) begin
      #1 dst_strobe = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    pixelstream src_if();
    rgbstream   dst_if();

    assign src_if.pixel  = src_pixel;
    assign src_if.write  = src_write;
    assign dst_if.strobe = dst_strobe;
    assign strobe_v[gi]  = src_if.strobe;
    assign dwrite_v[gi]  = dst_if.write;
    assign dpix_v[gi]    = dst_if.pixel;

    clut_lookup #(.PLANE_B(gi == 1)) dut (
      .clk      (clk),
      .reset    (reset),
      .src      (src_if),
      .dst      (dst_if),
      .cm       (cm),
      .pal_we   (pal_we),
      .pal_addr (pal_addr),
      .pal_data (pal_data)
    );

    logic [23:0] sb[$];
    logic        stall_prev = 1'b0;
    logic [23:0] pix_prev   = 24'h0;
    logic        rst_prev   = 1'b0;

    always @(negedge clk) begin
      logic        pop_now;
      logic        exp_stb;
      logic [23:0] e;
      int          pend;
      pop_now = dst_if.write && dst_strobe;
      if (rst_prev) check("dst_write_after_reset", 32'(dst_if.write), 32'd0);
      if (stall_prev) begin
        check("hold_write", 32'(dst_if.write), 32'd1);
        check("hold_pixel", 32'(dst_if.pixel), 32'(pix_prev));
      end
      // Items accepted but not yet delivered = occ + inflight.
      pend    = sb.size() - (pop_now ? 1 : 0);
      exp_stb = src_write && !reset && (pend < 2);
      check("src_strobe", 32'(src_if.strobe), 32'(exp_stb));
      if (reset) begin
        sb.delete();
      end else begin
        if (pop_now) begin
          if (sb.size() == 0) begin
            check("spurious_out", 32'(dst_if.write), 32'd0);
          end else begin
            e = sb.pop_front();
            check("pixel", 32'(dst_if.pixel), 32'(e));
            if (first_out[gi] < 0) first_out[gi] = cyc;
            last_out[gi] = cyc;
            out_cnt[gi]++;
          end
        end
        if (src_write && src_if.strobe)
          sb.push_back(pal_model[tb_idx(src_pixel, cm, gi == 1)]);
      end
      pend_v[gi] = sb.size();
      stall_prev = !reset && dst_if.write && !dst_strobe;
      pix_prev   = dst_if.pixel;
      rst_prev   = reset;
    end
  end

  task automatic send(input logic [7:0] p);
    int   t;
    logic acc;
    t = 0;
    src_write = 1'b1;
    src_pixel = p;
    do begin
      @(negedge clk);
      acc = strobe_v[0];
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((pend_v[0] != 0 || pend_v[1] != 0) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_done", (t < 50) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      out_cnt[i] = 0; first_out[i] = -1; last_out[i] = -1;
    end
  endtask

  initial begin
    int acc_cyc;
    reset = 1'b1; src_write = 1'b1; src_pixel = 8'hAA; dst_strobe = 1'b1;
    cm = kClut8; pal_we = 1'b0; pal_addr = 8'h0; pal_data = 24'h0;
    for (int i = 0; i < 2; i++) pend_v[i] = 0;
    clear_stats();

    // Palette load while in reset: entry k = {k, ~k, k ^ 0x55}.
    for (int k = 0; k < 256; k++) begin
      @(posedge clk); #1;
      pal_we   = 1'b1;
      pal_addr = 8'(k);
      pal_data = {8'(k), ~8'(k), 8'(k) ^ 8'h55};
    end
    @(posedge clk); #1;
    pal_we = 1'b0; src_write = 1'b0;
    check("rst_dst_write", 32'(dwrite_v[0]), 32'd0);
    check("rst_dst_pixel", 32'(dpix_v[0]), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Full ramp, kClut8, consumer always ready.
    clear_stats();
    for (int k = 0; k < 256; k++) begin
      send(8'(k));
      if (k == 0) acc_cyc = cyc;
    end
    src_write = 1'b0;
    drain();
    check("ramp_latency", 32'(first_out[0] - acc_cyc), 32'd1);
    check("ramp_no_gaps", 32'(last_out[0] - first_out[0]), 32'd255);
    check("ramp_count", 32'(out_cnt[0]), 32'd256);

    // Plane mapping and 4-bit mode.
    clear_stats();
    cm = kClut7;
    send(8'h05); send(8'h85);
    src_write = 1'b0; drain();
    cm = kClut4;
    send(8'hF3);
    src_write = 1'b0; drain();
    check("map_count_a", 32'(out_cnt[0]), 32'd3);
    check("map_count_b", 32'(out_cnt[1]), 32'd3);
    cm = kClut8;

    // Palette write colliding with a lookup of the same entry.
    clear_stats();
    pal_we = 1'b1; pal_addr = 8'd7; pal_data = 24'h123456;
    send(8'd7);
    pal_we = 1'b0;
    send(8'd7);
    src_write = 1'b0; drain();
    check("collision_count", 32'(out_cnt[0]), 32'd2);

    // Backpressure with consumer toggling 1,0,0,1.
    clear_stats();
    toggle_en = 1'b1;
    for (int k = 0; k < 40; k++) send(8'((k * 7) + 3));
    src_write = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    toggle_en = 1'b0; dst_strobe = 1'b1;
    drain();
    check("stall_count_a", 32'(out_cnt[0]), 32'd40);
    check("stall_count_b", 32'(out_cnt[1]), 32'd40);

    // Fill the FIFO, then reset mid-operation.
    dst_strobe = 1'b0; src_write = 1'b1; src_pixel = 8'h10;
    repeat (4) @(posedge clk);
    #1;
    check("full_pending", 32'(pend_v[0]), 32'd2);
    check("full_valid", 32'(dwrite_v[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_dst_write", 32'(dwrite_v[0]), 32'd0);
    check("reset_src_strobe", 32'(strobe_v[0]), 32'd0);
    reset = 1'b0; src_write = 1'b0; dst_strobe = 1'b1;
    @(posedge clk); #1;
    clear_stats();
    send(8'h20);
    acc_cyc = cyc;
    send(8'hFF);
    src_write = 1'b0; drain();
    check("post_reset_latency", 32'(first_out[0] - acc_cyc), 32'd1);
    check("post_reset_count", 32'(out_cnt[0]), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

`default_nettype wire
